// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store unit.
// The BEAT1 state exists only when MEM_SPLIT_MISALIGNED_EN is defined.
package mem_access_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BEAT0,
`ifdef MEM_SPLIT_MISALIGNED_EN
        BEAT1,
`endif
        CAPTURE,
        RESP
    } mem_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Wide enough for any supported lane count; callers truncate to BPW.
    localparam int MASK_W = 64;

    function automatic logic [MASK_W-1:0] byte_mask(input int first, input int last, input int bpw);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            m[i] = (i >= first) && (i <= last) && (i < bpw);
        end
        return m;
    endfunction

endpackage

// File: rtl/arilla_bus_if.sv
// Word-addressed, byte-enabled bus between a master and a memory slave.
interface arilla_bus_if #(
    parameter int WORD_ADDR_WIDTH = 30,
    parameter int DATA_WIDTH      = 32,
    parameter int BPW             = 4
);
    logic [WORD_ADDR_WIDTH-1:0] address;
    logic [BPW-1:0]             byte_en;
    logic                       read;
    logic                       write;
    logic [DATA_WIDTH-1:0]      data_ctp;
    logic [DATA_WIDTH-1:0]      data_ptc;
    logic                       inhibit;
    logic                       hit;

    modport master (
        output address, byte_en, read, write, data_ctp,
        input  data_ptc, inhibit, hit
    );

    modport slave (
        input  address, byte_en, read, write, data_ctp,
        output data_ptc, inhibit, hit
    );
endinterface

// File: rtl/mem_access_unit_extend.sv
// mem_load_extend: merges two beat words, aligns the addressed bytes to bit 0,
// truncates to the access size and sign/zero-extends.
module mem_load_extend #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int MAX_SIZE   = 2,
    parameter int SW         = 2
) (
    input  logic [DATA_WIDTH-1:0] d0,
    input  logic [DATA_WIDTH-1:0] d1,
    input  logic [MAX_SIZE-1:0]   start,
    input  logic [SW-1:0]         size,
    input  logic                  zext,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int BPW = DATA_WIDTH / BYTE_WIDTH;

    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] top_bit;
    logic                  sign;
    int                    nbits;

    always_comb begin
        merged = (d0 >> (int'(start) * BYTE_WIDTH))
               | (d1 << ((BPW - int'(start)) * BYTE_WIDTH));
        nbits  = (1 << int'(size)) * BYTE_WIDTH;
        if (nbits > DATA_WIDTH) begin
            nbits = DATA_WIDTH;
        end
        mask    = ~({DATA_WIDTH{1'b1}} << nbits);
        // Highest set bit of the mask marks the sign position.
        top_bit = mask & ~(mask >> 1);
        sign    = (|(merged & top_bit)) & ~zext;
        result  = (merged & mask) | (sign ? ~mask : '0);
    end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one request at a time, byte-enabled bus beats, registered response.
// Define MEM_SPLIT_MISALIGNED_EN to split word-crossing accesses into two beats.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    localparam int BPW       = DATA_WIDTH / BYTE_WIDTH,
    localparam int MAX_SIZE  = $clog2(BPW),
    localparam int SW        = $clog2(MAX_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    arilla_bus_if.master          bus_interface,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [SW:0]           req_sign_size,
    input  logic                  req_wr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_malign,
    output logic                  resp_fault,
    output logic [ADDR_WIDTH-1:0] resp_address
);
    localparam int WAW = ADDR_WIDTH - MAX_SIZE;

    mem_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SW-1:0]         size_q, size_d;
    logic                  zext_q, zext_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  fault_q, fault_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_malign_q, resp_malign_d;
    logic                  resp_fault_q, resp_fault_d;
    logic [ADDR_WIDTH-1:0] resp_address_q, resp_address_d;

    logic [MAX_SIZE-1:0]   start;
    int                    start_i, nbytes_i, end0_i, req_size_i, req_start_i;
    logic [WAW-1:0]        word_addr, beat_addr;
    logic [BPW-1:0]        beat_be;
    logic [DATA_WIDTH-1:0] beat_data, ext_d0, ext_d1, ext_result;
    logic                  in_beat, issue, rd_drv, wr_drv, too_big, req_malign;

    assign start       = addr_q[MAX_SIZE-1:0];
    assign start_i     = int'(start);
    assign nbytes_i    = 1 << int'(size_q);
    assign end0_i      = (start_i + nbytes_i > BPW) ? BPW - 1 : start_i + nbytes_i - 1;
    assign word_addr   = addr_q[ADDR_WIDTH-1:MAX_SIZE];
    assign req_size_i  = int'(req_sign_size[SW-1:0]);
    assign req_start_i = int'(req_address[MAX_SIZE-1:0]);
    assign too_big     = req_size_i > MAX_SIZE;

`ifdef MEM_SPLIT_MISALIGNED_EN
    logic [DATA_WIDTH-1:0] d0_q, d0_d;
    logic                  d0_pending_q, d0_pending_d;
    logic                  beat1_done_q, beat1_done_d;
    logic                  in_beat1, crosses;

    assign in_beat1   = (state_q == BEAT1);
    assign crosses    = (start_i + nbytes_i) > BPW;
    assign in_beat    = (state_q == BEAT0) || in_beat1;
    assign req_malign = too_big;
    assign beat_addr  = in_beat1 ? word_addr + WAW'(1) : word_addr;
    assign beat_be    = in_beat1 ? BPW'(byte_mask(0, start_i + nbytes_i - 1 - BPW, BPW))
                                 : BPW'(byte_mask(start_i, end0_i, BPW));
    assign beat_data  = in_beat1 ? wdata_q >> ((BPW - start_i) * BYTE_WIDTH)
                                 : wdata_q << (start_i * BYTE_WIDTH);
    assign ext_d0     = beat1_done_q ? d0_q : bus_interface.data_ptc;
    assign ext_d1     = beat1_done_q ? bus_interface.data_ptc : '0;
`else
    logic misalign;

    assign misalign   = (req_start_i & ((1 << req_size_i) - 1)) != 0;
    assign in_beat    = (state_q == BEAT0);
    assign req_malign = too_big || misalign;
    assign beat_addr  = word_addr;
    assign beat_be    = BPW'(byte_mask(start_i, end0_i, BPW));
    assign beat_data  = wdata_q << (start_i * BYTE_WIDTH);
    assign ext_d0     = bus_interface.data_ptc;
    assign ext_d1     = '0;
`endif

    assign issue  = in_beat && !bus_interface.inhibit;
    assign rd_drv = in_beat && !wr_q && bus_interface.hit;
    assign wr_drv = in_beat && wr_q && bus_interface.hit;

    // The slave owns the bus while it holds inhibit.
    assign bus_interface.address  = bus_interface.inhibit ? 'z : (in_beat ? beat_addr : '0);
    assign bus_interface.byte_en  = bus_interface.inhibit ? 'z : (in_beat ? beat_be : '0);
    assign bus_interface.data_ctp = bus_interface.inhibit ? 'z : (in_beat ? beat_data : '0);
    assign bus_interface.read     = bus_interface.inhibit ? 1'bz : rd_drv;
    assign bus_interface.write    = bus_interface.inhibit ? 1'bz : wr_drv;

    mem_load_extend #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .MAX_SIZE   (MAX_SIZE),
        .SW         (SW)
    ) u_extend (
        .d0     (ext_d0),
        .d1     (ext_d1),
        .start  (start),
        .size   (size_q),
        .zext   (zext_q),
        .result (ext_result)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        size_d         = size_q;
        zext_d         = zext_q;
        wr_d           = wr_q;
        wdata_d        = wdata_q;
        fault_d        = fault_q;
        resp_valid_d   = 1'b0;
        resp_rdata_d   = resp_rdata_q;
        resp_malign_d  = resp_malign_q;
        resp_fault_d   = resp_fault_q;
        resp_address_d = resp_address_q;
`ifdef MEM_SPLIT_MISALIGNED_EN
        d0_d           = d0_q;
        d0_pending_d   = 1'b0;
        beat1_done_d   = beat1_done_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_address;
                    size_d  = req_sign_size[SW-1:0];
                    zext_d  = req_sign_size[SW];
                    wr_d    = req_wr;
                    wdata_d = req_wdata;
                    fault_d = 1'b0;
`ifdef MEM_SPLIT_MISALIGNED_EN
                    beat1_done_d = 1'b0;
`endif
                    if (req_malign) begin
                        resp_valid_d   = 1'b1;
                        resp_rdata_d   = '0;
                        resp_malign_d  = 1'b1;
                        resp_fault_d   = 1'b0;
                        resp_address_d = req_address;
                        state_d        = RESP;
                    end else begin
                        state_d = BEAT0;
                    end
                end
            end
            BEAT0: begin
                if (issue) begin
                    fault_d = !bus_interface.hit;
`ifdef MEM_SPLIT_MISALIGNED_EN
                    if (crosses && bus_interface.hit) begin
                        state_d      = BEAT1;
                        d0_pending_d = 1'b1;
                    end else begin
                        state_d = CAPTURE;
                    end
`else
                    state_d = CAPTURE;
`endif
                end
            end
`ifdef MEM_SPLIT_MISALIGNED_EN
            BEAT1: begin
                // Beat-0 data is only on the bus the cycle right after it issued.
                if (d0_pending_q) begin
                    d0_d = bus_interface.data_ptc;
                end
                if (issue) begin
                    fault_d      = fault_q || !bus_interface.hit;
                    beat1_done_d = 1'b1;
                    state_d      = CAPTURE;
                end
            end
`endif
            CAPTURE: begin
                resp_valid_d   = 1'b1;
                resp_rdata_d   = wr_q ? '0 : ext_result;
                resp_malign_d  = 1'b0;
                resp_fault_d   = fault_q;
                resp_address_d = addr_q;
                state_d        = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            size_q         <= '0;
            zext_q         <= 1'b0;
            wr_q           <= 1'b0;
            wdata_q        <= '0;
            fault_q        <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_malign_q  <= 1'b0;
            resp_fault_q   <= 1'b0;
            resp_address_q <= '0;
`ifdef MEM_SPLIT_MISALIGNED_EN
            d0_q           <= '0;
            d0_pending_q   <= 1'b0;
            beat1_done_q   <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            size_q         <= size_d;
            zext_q         <= zext_d;
            wr_q           <= wr_d;
            wdata_q        <= wdata_d;
            fault_q        <= fault_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_malign_q  <= resp_malign_d;
            resp_fault_q   <= resp_fault_d;
            resp_address_q <= resp_address_d;
`ifdef MEM_SPLIT_MISALIGNED_EN
            d0_q           <= d0_d;
            d0_pending_q   <= d0_pending_d;
            beat1_done_q   <= beat1_done_d;
`endif
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_malign  = resp_malign_q;
    assign resp_fault   = resp_fault_q;
    assign resp_address = resp_address_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a one-cycle-latency memory slave.
// Expectations follow MEM_SPLIT_MISALIGNED_EN when it is defined for the build.
module tb_mem_access_unit;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int WAW = 30;
    localparam int BPW = 4;
`ifdef MEM_SPLIT_MISALIGNED_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_address = '0;
    logic [2:0]    req_sign_size = '0;
    logic          req_wr = 1'b0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_malign;
    logic          resp_fault;
    logic [AW-1:0] resp_address;

    always #5 clk = ~clk;

    arilla_bus_if #(.WORD_ADDR_WIDTH(WAW), .DATA_WIDTH(DW), .BPW(BPW)) bus ();

    mem_access_unit #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_interface (bus),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_address   (req_address),
        .req_sign_size (req_sign_size),
        .req_wr        (req_wr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_malign   (resp_malign),
        .resp_fault    (resp_fault),
        .resp_address  (resp_address)
    );

    // Slave: logs every issued beat, returns read data one cycle later.
    logic [DW-1:0]  rd_data [2];
    int             rd_base = 0;
    int             nrd = 0;
    int             nbeat = 0;
    int             viol = 0;
    logic [WAW-1:0] log_addr [16];
    logic [3:0]     log_be [16];
    logic [DW-1:0]  log_dat [16];

    always @(posedge clk) begin
        if (bus.read === 1'b1 || bus.write === 1'b1) begin
            log_addr[nbeat % 16] <= bus.address;
            log_be[nbeat % 16]   <= bus.byte_en;
            log_dat[nbeat % 16]  <= bus.data_ctp;
            nbeat                <= nbeat + 1;
        end
        if (bus.read === 1'b1) begin
            bus.data_ptc <= ((nrd - rd_base) == 0) ? rd_data[0] : rd_data[1];
            nrd          <= nrd + 1;
        end
        if (bus.inhibit === 1'b1 && (bus.read === 1'b1 || bus.write === 1'b1)) begin
            viol <= viol + 1;
        end
    end

    typedef struct {
        string          name;
        logic [AW-1:0]  addr;
        logic [2:0]     ss;
        logic           wr;
        logic [DW-1:0]  wdata;
        logic [DW-1:0]  d0;
        logic [DW-1:0]  d1;
        logic [DW-1:0]  e_rdata;
        logic           e_malign;
        logic           e_fault;
        int             e_lat;
        int             e_nb;
        logic [WAW-1:0] e_a0;
        logic [3:0]     e_be0;
        logic [DW-1:0]  e_w0;
        logic [WAW-1:0] e_a1;
        logic [3:0]     e_be1;
        logic [DW-1:0]  e_w1;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at #1 after a posedge; that cycle becomes cycle 0 (acceptance).
    task automatic apply_vec(input vec_t v, input logic [31:0] inh_mask, input logic [31:0] nohit_mask);
        int cyc;
        int base;
        bit got;
        base          = nbeat;
        rd_base       = nrd;
        rd_data[0]    = v.d0;
        rd_data[1]    = v.d1;
        req_address   = v.addr;
        req_sign_size = v.ss;
        req_wr        = v.wr;
        req_wdata     = v.wdata;
        req_valid     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc       = 1;
        got       = 1'b0;
        while (cyc <= 30 && !got) begin
            bus.inhibit = inh_mask[cyc[4:0]];
            bus.hit     = !nohit_mask[cyc[4:0]];
            if (resp_valid) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        bus.inhibit = 1'b0;
        bus.hit     = 1'b1;
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s timeout: no resp_valid within 30 cycles, expected cycle %0d", v.name, v.e_lat);
        end else begin
            $display("%s: addr=%h ss=%b wr=%b cycle=%0d rdata=%h malign=%b fault=%b beats=%0d",
                     v.name, v.addr, v.ss, v.wr, cyc, resp_rdata, resp_malign, resp_fault, nbeat - base);
            chk({v.name, " latency"}, cyc, v.e_lat);
            chk({v.name, " rdata"}, resp_rdata, v.e_rdata);
            chk({v.name, " malign"}, {31'd0, resp_malign}, {31'd0, v.e_malign});
            chk({v.name, " fault"}, {31'd0, resp_fault}, {31'd0, v.e_fault});
            chk({v.name, " resp_address"}, resp_address, v.addr);
            chk({v.name, " beats"}, nbeat - base, v.e_nb);
            if (v.e_nb > 0) begin
                chk({v.name, " beat0 addr"}, {2'b0, log_addr[base % 16]}, {2'b0, v.e_a0});
                chk({v.name, " beat0 be"}, {28'd0, log_be[base % 16]}, {28'd0, v.e_be0});
                if (v.wr) chk({v.name, " beat0 data"}, log_dat[base % 16], v.e_w0);
            end
            if (v.e_nb > 1) begin
                chk({v.name, " beat1 addr"}, {2'b0, log_addr[(base + 1) % 16]}, {2'b0, v.e_a1});
                chk({v.name, " beat1 be"}, {28'd0, log_be[(base + 1) % 16]}, {28'd0, v.e_be1});
                if (v.wr) chk({v.name, " beat1 data"}, log_dat[(base + 1) % 16], v.e_w1);
            end
            @(posedge clk);
            #1;
            chk({v.name, " valid one cycle"}, {31'd0, resp_valid}, 32'd0);
            chk({v.name, " ready after"}, {31'd0, req_ready}, 32'd1);
        end
    endtask

    vec_t vecs [13];
    vec_t hv;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit seen;

        vecs[0]  = '{"lw_aligned", 32'h100, 3'b010, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF,
                     1'b0, 1'b0, 3, 1, 30'h40, 4'b1111, 32'h0, 30'h0, 4'b0, 32'h0};
        vecs[1]  = '{"lb_sext", 32'h103, 3'b000, 1'b0, 32'h0, 32'h80123456, 32'h0, 32'hFFFFFF80,
                     1'b0, 1'b0, 3, 1, 30'h40, 4'b1000, 32'h0, 30'h0, 4'b0, 32'h0};
        vecs[2]  = '{"lbu_zext", 32'h103, 3'b100, 1'b0, 32'h0, 32'h80123456, 32'h0, 32'h00000080,
                     1'b0, 1'b0, 3, 1, 30'h40, 4'b1000, 32'h0, 30'h0, 4'b0, 32'h0};
        vecs[3]  = '{"lh_sext", 32'h102, 3'b001, 1'b0, 32'h0, 32'h80011234, 32'h0, 32'hFFFF8001,
                     1'b0, 1'b0, 3, 1, 30'h40, 4'b1100, 32'h0, 30'h0, 4'b0, 32'h0};
        vecs[4]  = '{"lhu_zext", 32'h100, 3'b101, 1'b0, 32'h0, 32'h1234ABCD, 32'h0, 32'h0000ABCD,
                     1'b0, 1'b0, 3, 1, 30'h40, 4'b0011, 32'h0, 30'h0, 4'b0, 32'h0};
        vecs[5]  = '{"sw_aligned", 32'h104, 3'b010, 1'b1, 32'h12345678, 32'h0, 32'h0, 32'h0,
                     1'b0, 1'b0, 3, 1, 30'h41, 4'b1111, 32'h12345678, 30'h0, 4'b0, 32'h0};
        vecs[6]  = '{"sb_lane1", 32'h101, 3'b000, 1'b1, 32'h000000A5, 32'h0, 32'h0, 32'h0,
                     1'b0, 1'b0, 3, 1, 30'h40, 4'b0010, 32'h0000A500, 30'h0, 4'b0, 32'h0};
        vecs[7]  = '{"size_too_big", 32'h100, 3'b011, 1'b0, 32'h0, 32'h11111111, 32'h0, 32'h0,
                     1'b1, 1'b0, 1, 0, 30'h0, 4'b0, 32'h0, 30'h0, 4'b0, 32'h0};
        vecs[8]  = '{"lh_mis_nocross", 32'h101, 3'b001, 1'b0, 32'h0, 32'h00ABCD00, 32'h0,
                     SPLIT ? 32'hFFFFABCD : 32'h0, !SPLIT, 1'b0, SPLIT ? 3 : 1, SPLIT ? 1 : 0,
                     30'h40, 4'b0110, 32'h0, 30'h0, 4'b0, 32'h0};
        vecs[9]  = '{"lh_split", 32'h103, 3'b001, 1'b0, 32'h0, 32'hAB000000, 32'h000000CD,
                     SPLIT ? 32'hFFFFCDAB : 32'h0, !SPLIT, 1'b0, SPLIT ? 4 : 1, SPLIT ? 2 : 0,
                     30'h40, 4'b1000, 32'h0, 30'h41, 4'b0001, 32'h0};
        vecs[10] = '{"sw_split", 32'h102, 3'b010, 1'b1, 32'h12345678, 32'h0, 32'h0, 32'h0,
                     !SPLIT, 1'b0, SPLIT ? 4 : 1, SPLIT ? 2 : 0,
                     30'h40, 4'b1100, 32'h56780000, 30'h41, 4'b0011, 32'h00001234};
        vecs[11] = '{"lw_split_wrap", 32'hFFFFFFFE, 3'b010, 1'b0, 32'h0, 32'hBEEF0000, 32'h0000CAFE,
                     SPLIT ? 32'hCAFEBEEF : 32'h0, !SPLIT, 1'b0, SPLIT ? 4 : 1, SPLIT ? 2 : 0,
                     30'h3FFFFFFF, 4'b1100, 32'h0, 30'h0, 4'b0011, 32'h0};
        vecs[12] = '{"lb_positive", 32'h200, 3'b000, 1'b0, 32'h0, 32'h1234567F, 32'h0, 32'h0000007F,
                     1'b0, 1'b0, 3, 1, 30'h80, 4'b0001, 32'h0, 30'h0, 4'b0, 32'h0};

        bus.inhibit = 1'b0;
        bus.hit     = 1'b1;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("reset: ready=%b valid=%b rdata=%h malign=%b fault=%b addr=%h",
                 req_ready, resp_valid, resp_rdata, resp_malign, resp_fault, resp_address);
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_malign", {31'd0, resp_malign}, 32'd0);
        chk("reset resp_fault", {31'd0, resp_fault}, 32'd0);
        chk("reset resp_address", resp_address, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            apply_vec(vecs[i], 32'd0, 32'd0);
        end

        // Three inhibit cycles while BEAT0 is pending.
        hv = '{"stall_beat0", 32'h100, 3'b010, 1'b0, 32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D,
               1'b0, 1'b0, 6, 1, 30'h40, 4'b1111, 32'h0, 30'h0, 4'b0, 32'h0};
        apply_vec(hv, 32'b1110, 32'd0);
        chk("stall no access while inhibited", viol, 0);

        // hit low on an aligned store beat.
        hv = '{"fault_aligned_store", 32'h108, 3'b010, 1'b1, 32'hAAAA5555, 32'h0, 32'h0, 32'h0,
               1'b0, 1'b1, 3, 0, 30'h0, 4'b0, 32'h0, 30'h0, 4'b0, 32'h0};
        apply_vec(hv, 32'd0, 32'b0010);

`ifdef MEM_SPLIT_MISALIGNED_EN
        // hit low on beat 0 of a split store: BEAT1 skipped, nothing written.
        hv = '{"fault_split_store", 32'h102, 3'b010, 1'b1, 32'h12345678, 32'h0, 32'h0, 32'h0,
               1'b0, 1'b1, 3, 0, 30'h0, 4'b0, 32'h0, 30'h0, 4'b0, 32'h0};
        apply_vec(hv, 32'd0, 32'b0010);
`endif

        // Reset mid-operation: during BEAT1 when splitting, else during BEAT0.
        rd_base       = nrd;
        rd_data[0]    = 32'hAB000000;
        rd_data[1]    = 32'h000000CD;
        req_address   = SPLIT ? 32'h103 : 32'h100;
        req_sign_size = SPLIT ? 3'b001 : 3'b010;
        req_wr        = 1'b0;
        req_valid     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
`ifdef MEM_SPLIT_MISALIGNED_EN
        @(posedge clk);
        #1;
`endif
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("mid_reset: ready=%b valid=%b rdata=%h", req_ready, resp_valid, resp_rdata);
        chk("mid_reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_reset resp_rdata", resp_rdata, 32'd0);
        base = nbeat;
        seen = 1'b0;
        repeat (6) begin
            if (resp_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("mid_reset no late resp_valid", {31'd0, seen}, 32'd0);
        chk("mid_reset no further beats", nbeat - base, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
